wb_copy_master: RTL and testbench

Wishbone classic single-cycle bus master that copies a block of 32-bit words from a source address range to a destination address range without CPU involvement. It plugs into a spare master port of the `wb_conmax_top` interconnect, next to the CPU's instruction and data masters. Typical uses are preloading instruction RAM from data RAM and block-filling peripheral windows. It drives the master side of the same handshake that `BRAM` and `decoder` answer as slaves.

---
 rtl/wb_copy_master_pkg.sv | 21 ++
 rtl/wb_copy_master.sv | 202 ++++++++++++++++++++
 tb/tb_wb_copy_master.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_copy_master_pkg.sv
// Shared definitions for the Wishbone block-copy master: FSM states, bus
// constants and address alignment helper.
package wb_copy_master_pkg;

   typedef enum logic [1:0] {
      COPY_IDLE  = 2'd0,
      COPY_READ  = 2'd1,
      COPY_WRITE = 2'd2,
      COPY_PAUSE = 2'd3
   } copy_state_e;

   localparam logic [3:0]  SEL_WORD  = 4'b1111;
   localparam logic [31:0] ADDR_STEP = 32'd4;
   localparam logic [31:0] ZeroWord  = 32'h0000_0000;
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & WORD_MASK;
   endfunction

endpackage

// File: rtl/wb_copy_master.sv
// Wishbone classic master that copies a block of 32-bit words from a source
// range to a destination range, one read/write pair per word.
module wb_copy_master
   import wb_copy_master_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int LEN_W   = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             cmd_start_i,
   input  logic [31:0]      cmd_src_i,
   input  logic [31:0]      cmd_dst_i,
   input  logic [LEN_W-1:0] cmd_len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [LEN_W-1:0] words_left_o,
   output logic [31:0]      wb_adr_o,
   output logic [31:0]      wb_dat_o,
   output logic [3:0]       wb_sel_o,
   output logic             wb_we_o,
   output logic             wb_cyc_o,
   output logic             wb_stb_o,
   input  logic [31:0]      wb_dat_i,
   input  logic             wb_ack_i,
   input  logic             wb_err_i
);

   // The counter holds the number of stalled cycles already spent in this
   // phase, so a phase aborts after exactly TIMEOUT cycles without response.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   copy_state_e      state_q, state_d;
   logic [31:0]      src_q, src_d;
   logic [31:0]      dst_q, dst_d;
   logic [31:0]      adr_q, adr_d;
   logic [31:0]      dat_q, dat_d;
   logic [LEN_W-1:0] left_q, left_d;
   logic [7:0]       tmo_q, tmo_d;
   logic [3:0]       sel_q, sel_d;
   logic             cyc_q, cyc_d;
   logic             we_q, we_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             abort;

   // Next-state and next-output logic; every bus output is computed here and
   // registered below so nothing on the bus depends combinationally on inputs.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      left_d  = left_q;
      tmo_d   = tmo_q;
      sel_d   = 4'b0000;
      cyc_d   = 1'b0;
      we_d    = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      abort   = 1'b0;

      case (state_q)
         COPY_IDLE: begin
            busy_d = 1'b0;
            if (cmd_start_i) begin
               if (cmd_len_i != '0) begin
                  state_d = COPY_READ;
                  src_d   = word_align(cmd_src_i);
                  dst_d   = word_align(cmd_dst_i);
                  adr_d   = word_align(cmd_src_i);
                  left_d  = cmd_len_i;
                  tmo_d   = 8'd0;
                  cyc_d   = 1'b1;
                  sel_d   = SEL_WORD;
                  busy_d  = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end

         COPY_READ: begin
            if (wb_err_i) begin
               abort = 1'b1;
            end else if (wb_ack_i) begin
               state_d = COPY_WRITE;
               dat_d   = wb_dat_i;
               adr_d   = dst_q;
               tmo_d   = 8'd0;
               cyc_d   = 1'b1;
               we_d    = 1'b1;
               sel_d   = SEL_WORD;
            end else if (tmo_q == TMO_LAST) begin
               abort = 1'b1;
            end else begin
               tmo_d = tmo_q + 8'd1;
               cyc_d = 1'b1;
               sel_d = SEL_WORD;
            end
         end

         COPY_WRITE: begin
            if (wb_err_i) begin
               abort = 1'b1;
            end else if (wb_ack_i) begin
               state_d = COPY_PAUSE;
               src_d   = src_q + ADDR_STEP;
               dst_d   = dst_q + ADDR_STEP;
               left_d  = left_q - LEN_W'(1);
            end else if (tmo_q == TMO_LAST) begin
               abort = 1'b1;
            end else begin
               tmo_d = tmo_q + 8'd1;
               cyc_d = 1'b1;
               we_d  = 1'b1;
               sel_d = SEL_WORD;
            end
         end

         COPY_PAUSE: begin
            // The idle bus cycle lets the interconnect hand the bus back to the CPU.
            if (left_q != '0) begin
               state_d = COPY_READ;
               adr_d   = src_q;
               tmo_d   = 8'd0;
               cyc_d   = 1'b1;
               sel_d   = SEL_WORD;
            end else begin
               state_d = COPY_IDLE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end
         end

         default: begin
            state_d = COPY_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // Abort leaves words_left untouched so it reports the words not written.
      if (abort) begin
         state_d = COPY_IDLE;
         done_d  = 1'b1;
         err_d   = 1'b1;
         busy_d  = 1'b0;
         cyc_d   = 1'b0;
         we_d    = 1'b0;
         sel_d   = 4'b0000;
      end
   end

   // State and registered outputs; reset clears the bus immediately.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= COPY_IDLE;
         src_q   <= ZeroWord;
         dst_q   <= ZeroWord;
         adr_q   <= ZeroWord;
         dat_q   <= ZeroWord;
         left_q  <= '0;
         tmo_q   <= 8'd0;
         sel_q   <= 4'b0000;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         left_q  <= left_d;
         tmo_q   <= tmo_d;
         sel_q   <= sel_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign wb_adr_o     = adr_q;
   assign wb_dat_o     = dat_q;
   assign wb_sel_o     = sel_q;
   assign wb_we_o      = we_q;
   assign wb_cyc_o     = cyc_q;
   assign wb_stb_o     = cyc_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign words_left_o = left_q;

endmodule

// File: tb/tb_wb_copy_master.sv
// Self-checking bench for wb_copy_master: registered-ack slave model with
// memory, bus monitor, and a transaction-level reference of the block copy.
module tb_wb_copy_master;

   localparam int TMO = 8;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i;
   logic        cmd_start_i;
   logic [31:0] cmd_src_i, cmd_dst_i;
   logic [15:0] cmd_len_i;
   logic        busy_o, done_o, err_o;
   logic [15:0] words_left_o;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
   } txn_t;

   txn_t        log_q[$];
   txn_t        exp_q[$];
   logic [31:0] mem [logic [31:0]];

   int          na = 1;
   bit          stall = 0;
   bit          err_en = 0;
   logic [31:0] err_addr = 32'h0;
   int          wait_cnt;

   int checks = 0;
   int errors = 0;
   int cyc_cnt = 0, pause_cnt = 0, idle_bad = 0, stable_bad = 0;
   logic        prev_stall = 1'b0, prev_we = 1'b0;
   logic [31:0] prev_adr = 32'h0, prev_dat = 32'h0;

   always #5 wb_clk_i = ~wb_clk_i;

   wb_copy_master #(.TIMEOUT(TMO), .LEN_W(16)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .cmd_start_i(cmd_start_i), .cmd_src_i(cmd_src_i), .cmd_dst_i(cmd_dst_i),
      .cmd_len_i(cmd_len_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .words_left_o(words_left_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
      .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
      .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
      .wb_err_i(wb_err_i)
   );

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return init_word(a);
   endfunction

   // Slave with registered ack arriving na cycles after stb.
   always @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wb_ack_i <= 1'b0;
         wb_err_i <= 1'b0;
         wb_dat_i <= 32'h0;
         wait_cnt <= 0;
      end else begin
         wb_ack_i <= 1'b0;
         wb_err_i <= 1'b0;
         wb_dat_i <= $urandom;
         if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i && !stall) begin
            if (wait_cnt + 1 >= na) begin
               wait_cnt <= 0;
               if (err_en && wb_we_o && wb_adr_o == err_addr) wb_err_i <= 1'b1;
               else begin
                  wb_ack_i <= 1'b1;
                  if (wb_we_o) mem[wb_adr_o] = wb_dat_o;
                  else wb_dat_i <= mem_rd(wb_adr_o);
               end
            end else wait_cnt <= wait_cnt + 1;
         end else wait_cnt <= 0;
      end
   end

   // Bus monitor, sampled mid-cycle.
   always @(negedge wb_clk_i) begin
      if (wb_cyc_o && wb_stb_o && wb_ack_i)
         log_q.push_back('{we: wb_we_o, adr: wb_adr_o,
                           dat: (wb_we_o ? wb_dat_o : wb_dat_i), sel: wb_sel_o});
      if (wb_cyc_o) cyc_cnt++;
      if (busy_o && !wb_cyc_o) pause_cnt++;
      if (!wb_cyc_o && (wb_we_o || wb_sel_o != 4'h0)) idle_bad++;
      if (wb_stb_o && prev_stall &&
          (wb_adr_o != prev_adr || wb_we_o != prev_we || wb_dat_o != prev_dat))
         stable_bad++;
      prev_stall = wb_stb_o && !wb_ack_i && !wb_err_i;
      prev_adr   = wb_adr_o;
      prev_we    = wb_we_o;
      prev_dat   = wb_dat_o;
   end

   // Reference: every word is one read at src+4i then one write at dst+4i.
   task automatic model_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
      logic [31:0] s, d;
      exp_q.delete();
      s = src & 32'hFFFF_FFFC;
      d = dst & 32'hFFFF_FFFC;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{we: 1'b0, adr: s + 32'(4 * i), dat: init_word(s + 32'(4 * i)), sel: 4'hF});
         exp_q.push_back('{we: 1'b1, adr: d + 32'(4 * i), dat: init_word(s + 32'(4 * i)), sel: 4'hF});
      end
   endtask

   task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst,
                                input logic [15:0] len);
      @(negedge wb_clk_i);
      cmd_src_i   = src;
      cmd_dst_i   = dst;
      cmd_len_i   = len;
      cmd_start_i = 1'b1;
      @(negedge wb_clk_i);
      cmd_start_i = 1'b0;
   endtask

   // Starts a copy and counts cycles (1 = cycle after acceptance) until done.
   task automatic run_copy(input logic [31:0] src, input logic [31:0] dst,
                           input logic [15:0] len, input int mid_at,
                           output int k, output int busy_cycles,
                           output logic err_at_done, output logic [15:0] left_at_done);
      applyStimulus(src, dst, len);
      k = 1;
      busy_cycles = 0;
      while (!done_o && k < 2000) begin
         if (busy_o) busy_cycles++;
         if (k == mid_at) begin
            cmd_start_i = 1'b1;
            cmd_src_i   = 32'h0BAD_0000;
            cmd_len_i   = 16'd7;
         end else cmd_start_i = 1'b0;
         @(negedge wb_clk_i);
         k++;
      end
      cmd_start_i  = 1'b0;
      err_at_done  = err_o;
      left_at_done = words_left_o;
   endtask

   task automatic test_reset();
      wb_rst_i = 1'b1;
      cmd_start_i = 1'b0; cmd_src_i = 32'h0; cmd_dst_i = 32'h0; cmd_len_i = 16'h0;
      repeat (3) @(negedge wb_clk_i);
      checks++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'h0) begin
         errors++; $display("[TB] FAIL reset_bus_ctrl: got %h expected 0", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o});
      end
      checks++;
      if ({wb_adr_o, wb_dat_o} !== 64'h0) begin
         errors++; $display("[TB] FAIL reset_adr_dat: got %h expected 0", {wb_adr_o, wb_dat_o});
      end
      checks++;
      if ({busy_o, done_o, err_o, words_left_o} !== 19'h0) begin
         errors++; $display("[TB] FAIL reset_status: got %h expected 0", {busy_o, done_o, err_o, words_left_o});
      end
      wb_rst_i = 1'b0;
      repeat (2) @(negedge wb_clk_i);
   endtask

   task automatic test_basic();
      int k, bc, base, p0, i0, s0;
      logic e;
      logic [15:0] left;
      na = 1;
      base = log_q.size(); p0 = pause_cnt; i0 = idle_bad; s0 = stable_bad;
      run_copy(32'h0000_0100, 32'h2000_0200, 16'd3, 0, k, bc, e, left);
      model_copy(32'h0000_0100, 32'h2000_0200, 3);
      checks++;
      if (log_q.size() - base != exp_q.size()) begin
         errors++; $display("[TB] FAIL basic_txn_count: got %0d expected %0d", log_q.size() - base, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++) begin
         checks++;
         if ({log_q[base+i].we, log_q[base+i].adr, log_q[base+i].dat, log_q[base+i].sel} !==
             {exp_q[i].we, exp_q[i].adr, exp_q[i].dat, exp_q[i].sel}) begin
            errors++;
            $display("[TB] FAIL basic_txn%0d: got we=%b adr=%h dat=%h sel=%h expected we=%b adr=%h dat=%h sel=%h", i,
                     log_q[base+i].we, log_q[base+i].adr, log_q[base+i].dat, log_q[base+i].sel,
                     exp_q[i].we, exp_q[i].adr, exp_q[i].dat, exp_q[i].sel);
         end
      end
      checks++;
      if (k != 3 * 5 + 1) begin errors++; $display("[TB] FAIL basic_done_cycle: got %0d expected %0d", k, 16); end
      checks++;
      if (bc != 15) begin errors++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 15", bc); end
      checks++;
      if (e !== 1'b0 || left !== 16'd0) begin
         errors++; $display("[TB] FAIL basic_err_left: got err=%b left=%0d expected err=0 left=0", e, left);
      end
      checks++;
      if (pause_cnt - p0 != 3) begin errors++; $display("[TB] FAIL basic_pause_cycles: got %0d expected 3", pause_cnt - p0); end
      checks++;
      if (idle_bad - i0 != 0 || stable_bad - s0 != 0) begin
         errors++; $display("[TB] FAIL basic_idle_stable: got %0d/%0d expected 0/0", idle_bad - i0, stable_bad - s0);
      end
      @(negedge wb_clk_i);
      checks++;
      if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_width: got %b expected 0", done_o); end
   endtask

   task automatic test_random();
      int k, bc, base, n;
      logic e;
      logic [15:0] left;
      logic [31:0] src, dst, sa, da;
      for (int it = 0; it < 5; it++) begin
         na  = $urandom_range(1, 3);
         n   = $urandom_range(1, 6);
         src = 32'h1000_0000 + 32'(it) * 32'h0001_0000 + ($urandom & 32'h0000_FFFF);
         dst = 32'h5000_0000 + 32'(it) * 32'h0001_0000 + ($urandom & 32'h0000_FFFF);
         sa  = src & 32'hFFFF_FFFC;
         da  = dst & 32'hFFFF_FFFC;
         base = log_q.size();
         run_copy(src, dst, 16'(n), 0, k, bc, e, left);
         model_copy(src, dst, n);
         checks++;
         if (log_q.size() - base != exp_q.size()) begin
            errors++; $display("[TB] FAIL rand%0d_txn_count: got %0d expected %0d", it, log_q.size() - base, exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++) begin
            checks++;
            if ({log_q[base+i].we, log_q[base+i].adr, log_q[base+i].dat} !==
                {exp_q[i].we, exp_q[i].adr, exp_q[i].dat}) begin
               errors++;
               $display("[TB] FAIL rand%0d_txn%0d: got we=%b adr=%h dat=%h expected we=%b adr=%h dat=%h", it, i,
                        log_q[base+i].we, log_q[base+i].adr, log_q[base+i].dat,
                        exp_q[i].we, exp_q[i].adr, exp_q[i].dat);
            end
         end
         checks++;
         if (k != n * (2 * na + 3) + 1) begin
            errors++; $display("[TB] FAIL rand%0d_done_cycle: got %0d expected %0d", it, k, n * (2 * na + 3) + 1);
         end
         checks++;
         if (e !== 1'b0 || left !== 16'd0) begin
            errors++; $display("[TB] FAIL rand%0d_err_left: got err=%b left=%0d expected 0/0", it, e, left);
         end
         for (int i = 0; i < n; i++) begin
            checks++;
            if (mem_rd(da + 32'(4 * i)) !== init_word(sa + 32'(4 * i))) begin
               errors++; $display("[TB] FAIL rand%0d_mem%0d: got %h expected %h", it, i,
                                  mem_rd(da + 32'(4 * i)), init_word(sa + 32'(4 * i)));
            end
         end
      end
   endtask

   task automatic test_len_zero();
      int k, bc, c0;
      logic e;
      logic [15:0] left;
      c0 = cyc_cnt;
      run_copy(32'h0000_0400, 32'h0000_0800, 16'd0, 0, k, bc, e, left);
      checks++;
      if (k != 1) begin errors++; $display("[TB] FAIL len0_done_cycle: got %0d expected 1", k); end
      checks++;
      if (bc != 0 || e !== 1'b0) begin errors++; $display("[TB] FAIL len0_busy_err: got %0d/%b expected 0/0", bc, e); end
      repeat (3) @(negedge wb_clk_i);
      checks++;
      if (cyc_cnt - c0 != 0 || done_o !== 1'b0) begin
         errors++; $display("[TB] FAIL len0_no_bus: got cyc=%0d done=%b expected 0/0", cyc_cnt - c0, done_o);
      end
   endtask

   task automatic test_write_error();
      int n, base;
      na = 1; err_en = 1'b1; err_addr = 32'h0A00_0004;
      base = log_q.size();
      applyStimulus(32'h0900_0000, 32'h0A00_0000, 16'd4);
      n = 0;
      while (!wb_err_i && n < 200) begin @(negedge wb_clk_i); n++; end
      checks++;
      if (n >= 200) begin errors++; $display("[TB] FAIL werr_seen: got none expected err response"); end
      @(negedge wb_clk_i);
      checks++;
      if ({wb_cyc_o, wb_stb_o, done_o, err_o} !== 4'b0011) begin
         errors++; $display("[TB] FAIL werr_abort: got cyc/stb/done/err=%b expected 0011", {wb_cyc_o, wb_stb_o, done_o, err_o});
      end
      checks++;
      if (words_left_o !== 16'd3) begin errors++; $display("[TB] FAIL werr_left: got %0d expected 3", words_left_o); end
      @(negedge wb_clk_i);
      checks++;
      if ({done_o, err_o, busy_o} !== 3'b000) begin
         errors++; $display("[TB] FAIL werr_pulse: got %b expected 000", {done_o, err_o, busy_o});
      end
      checks++;
      if (log_q.size() - base != 3) begin errors++; $display("[TB] FAIL werr_txns: got %0d expected 3", log_q.size() - base); end
      checks++;
      if (mem_rd(32'h0A00_0000) !== init_word(32'h0900_0000) || mem.exists(32'h0A00_0004)) begin
         errors++; $display("[TB] FAIL werr_mem: got %h expected %h with word 2 unwritten",
                            mem_rd(32'h0A00_0000), init_word(32'h0900_0000));
      end
      err_en = 1'b0;
   endtask

   task automatic test_timeout();
      int n, c0;
      stall = 1'b1;
      c0 = cyc_cnt;
      applyStimulus(32'h0B00_0000, 32'h0C00_0000, 16'd5);
      n = 1;
      while (!done_o && n < 100) begin @(negedge wb_clk_i); n++; end
      checks++;
      if (cyc_cnt - c0 != TMO) begin errors++; $display("[TB] FAIL tmo_stall_cycles: got %0d expected %0d", cyc_cnt - c0, TMO); end
      checks++;
      if ({done_o, err_o, wb_cyc_o} !== 3'b110) begin
         errors++; $display("[TB] FAIL tmo_abort: got done/err/cyc=%b expected 110", {done_o, err_o, wb_cyc_o});
      end
      checks++;
      if (words_left_o !== 16'd5) begin errors++; $display("[TB] FAIL tmo_left: got %0d expected 5", words_left_o); end
      stall = 1'b0;
      @(negedge wb_clk_i);
   endtask

   task automatic test_start_while_busy();
      int k, bc, base, c0;
      logic e;
      logic [15:0] left;
      na = 1;
      base = log_q.size();
      run_copy(32'hFFFF_FFFF, 32'h3000_0001, 16'd2, 3, k, bc, e, left);
      model_copy(32'hFFFF_FFFF, 32'h3000_0001, 2);
      checks++;
      if (log_q.size() - base != 4) begin errors++; $display("[TB] FAIL wrap_txn_count: got %0d expected 4", log_q.size() - base); end
      for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++) begin
         checks++;
         if ({log_q[base+i].we, log_q[base+i].adr, log_q[base+i].dat} !==
             {exp_q[i].we, exp_q[i].adr, exp_q[i].dat}) begin
            errors++;
            $display("[TB] FAIL wrap_txn%0d: got we=%b adr=%h dat=%h expected we=%b adr=%h dat=%h", i,
                     log_q[base+i].we, log_q[base+i].adr, log_q[base+i].dat,
                     exp_q[i].we, exp_q[i].adr, exp_q[i].dat);
         end
      end
      checks++;
      if (k != 11 || e !== 1'b0) begin errors++; $display("[TB] FAIL wrap_done: got cycle=%0d err=%b expected 11/0", k, e); end
      c0 = cyc_cnt;
      repeat (5) @(negedge wb_clk_i);
      checks++;
      if (cyc_cnt - c0 != 0 || busy_o !== 1'b0) begin
         errors++; $display("[TB] FAIL busy_start_ignored: got cyc=%0d busy=%b expected 0/0", cyc_cnt - c0, busy_o);
      end
   endtask

   task automatic test_reset_mid_write();
      int n, k, bc, base;
      logic e;
      logic [15:0] left;
      na = 2;
      applyStimulus(32'h0700_0000, 32'h0800_0000, 16'd4);
      n = 0;
      while (!(wb_we_o && wb_stb_o) && n < 50) begin @(negedge wb_clk_i); n++; end
      #2 wb_rst_i = 1'b1;
      #1;
      checks++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, busy_o, done_o, err_o, words_left_o} !== 90'h0) begin
         errors++; $display("[TB] FAIL rst_async: got cyc=%b we=%b adr=%h dat=%h busy=%b left=%0d expected all 0",
                            wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o, busy_o, words_left_o);
      end
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      base = log_q.size();
      run_copy(32'h0710_0000, 32'h0810_0000, 16'd3, 0, k, bc, e, left);
      checks++;
      if (k != 3 * 7 + 1 || e !== 1'b0 || left !== 16'd0) begin
         errors++; $display("[TB] FAIL rst_fresh_done: got cycle=%0d err=%b left=%0d expected 22/0/0", k, e, left);
      end
      checks++;
      if (log_q.size() - base != 6) begin errors++; $display("[TB] FAIL rst_fresh_txns: got %0d expected 6", log_q.size() - base); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (mem_rd(32'h0810_0000 + 32'(4 * i)) !== init_word(32'h0710_0000 + 32'(4 * i))) begin
            errors++; $display("[TB] FAIL rst_fresh_mem%0d: got %h expected %h", i,
                               mem_rd(32'h0810_0000 + 32'(4 * i)), init_word(32'h0710_0000 + 32'(4 * i)));
         end
      end
   endtask

   task automatic checkOutput();
      checks++;
      if (idle_bad != 0 || stable_bad != 0) begin
         errors++; $display("[TB] FAIL global_idle_stable: got %0d/%0d expected 0/0", idle_bad, stable_bad);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_random();
      test_len_zero();
      test_write_error();
      test_timeout();
      test_start_while_busy();
      test_reset_mid_write();
      checkOutput();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got no completion expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
